// File: rtl/march_element_ctrl.sv
// Sequencer for one march element: walks the address counter over the whole
// address space and issues 1..4 datapath operations per address.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef IR_BFW_ADMD
`define IR_BFW_ADMD 2
`endif
`ifndef ADMD_LIUD
`define ADMD_LIUD 2'd0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 2'd1
`endif
`ifndef ADDR_UP
`define ADDR_UP 1'b1
`endif
`ifndef ADMD_PR_SEED
`define ADMD_PR_SEED 8'h01
`endif

module march_element_ctrl #(
  parameter int TASW = `ADDR_WIDTH,
  parameter int ADMW = `IR_BFW_ADMD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            dir_in,
  input  logic [ADMW-1:0] admd_in,
  input  logic [1:0]      nops_in,
  input  logic            op_ack_in,
  input  logic            abort_in,
  output logic            s_out,
  output logic            r_out,
  output logic            hold_out,
  output logic            updwn_out,
  output logic [ADMW-1:0] admd_out,
  output logic            op_req_out,
  output logic [1:0]      op_idx_out,
  output logic            busy_out,
  output logic            done_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_OP, S_STEP, S_DONE} state_t;

  // LFSR mode has one address fewer: the all-zero state is never reached
  localparam logic [TASW:0] LAST_LI = {1'b0, {TASW{1'b1}}};
  localparam logic [TASW:0] LAST_PR = LAST_LI - (TASW+1)'(1);

  state_t          state_q, state_d;
  logic            dir_q, dir_d;
  logic [ADMW-1:0] admd_q, admd_d;
  logic [1:0]      nops_q, nops_d;
  logic [1:0]      idx_q, idx_d;
  logic [TASW:0]   visit_q, visit_d;
  logic            last_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      admd_q  <= '0;
      nops_q  <= 2'd0;
      idx_q   <= 2'd0;
      visit_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      admd_q  <= admd_d;
      nops_q  <= nops_d;
      idx_q   <= idx_d;
      visit_q <= visit_d;
    end
  end

  assign last_addr = (admd_q == ADMW'(`ADMD_PRUD)) ? (visit_q == LAST_PR)
                                                   : (visit_q == LAST_LI);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    admd_d     = admd_q;
    nops_d     = nops_q;
    idx_d      = idx_q;
    visit_d    = visit_q;
    s_out      = 1'b0;
    r_out      = 1'b0;
    hold_out   = 1'b1;
    op_req_out = 1'b0;
    busy_out   = 1'b1;
    done_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) begin
          dir_d   = dir_in;
          admd_d  = admd_in;
          nops_d  = nops_in;
          idx_d   = 2'd0;
          visit_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        s_out    = ~dir_q;
        r_out    = dir_q;
        hold_out = 1'b0;
        state_d  = S_OP;
      end
      S_OP: begin
        op_req_out = 1'b1;
        if (op_ack_in) begin
          if (idx_q != nops_q) begin
            idx_d = idx_q + 2'd1;
          end else begin
            idx_d = 2'd0;
            if (last_addr) begin
              state_d = S_DONE;
            end else begin
              visit_d = visit_q + (TASW+1)'(1);
              state_d = S_STEP;
            end
          end
        end
      end
      S_STEP: begin
        hold_out = 1'b0;
        state_d  = S_OP;
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort outranks any completion in the same cycle
    if (abort_in && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end

  assign updwn_out  = dir_q ? ~`ADDR_UP : `ADDR_UP;
  assign admd_out   = admd_q;
  assign op_idx_out = idx_q;

endmodule

// File: tb/tb_march_element_ctrl.sv
// Randomised and directed bench for march_element_ctrl against an
// operation-count model plus a behavioural address counter.
`ifndef ADMD_LIUD
`define ADMD_LIUD 2'd0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 2'd1
`endif
`ifndef ADDR_UP
`define ADDR_UP 1'b1
`endif
`ifndef ADMD_PR_SEED
`define ADMD_PR_SEED 8'h01
`endif

module tb_march_element_ctrl;
  localparam int TASW = 8;
  localparam int ADMW = 2;
  localparam logic [1:0] LIUD = `ADMD_LIUD;
  localparam logic [1:0] PRUD = `ADMD_PRUD;
  localparam logic [7:0] SEED = `ADMD_PR_SEED;
  localparam logic [10:0] RESET_VEC = {1'b0, 1'b0, 1'b1, `ADDR_UP, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1, start_in = 1'b0, dir_in = 1'b0, op_ack_in = 1'b0, abort_in = 1'b0;
  logic [ADMW-1:0] admd_in = '0;
  logic [1:0] nops_in = 2'd0;
  logic s_out, r_out, hold_out, updwn_out, op_req_out, busy_out, done_out;
  logic [ADMW-1:0] admd_out;
  logic [1:0] op_idx_out;

  march_element_ctrl #(.TASW(TASW), .ADMW(ADMW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .dir_in(dir_in), .admd_in(admd_in),
    .nops_in(nops_in), .op_ack_in(op_ack_in), .abort_in(abort_in),
    .s_out(s_out), .r_out(r_out), .hold_out(hold_out), .updwn_out(updwn_out),
    .admd_out(admd_out), .op_req_out(op_req_out), .op_idx_out(op_idx_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an element is a count of completed operations; phase is only
  // the idle / load / run / step / done bookkeeping around that count.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_STEP, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  logic m_dir = 1'b0;
  logic [1:0] m_admd = 2'd0;
  int m_n = 1, m_ops = 0, cyc = 0, m_t0 = 0;

  function automatic int n_addr(input logic [1:0] a);
    return (a == PRUD) ? 255 : 256;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ph = M_IDLE; m_dir = 1'b0; m_admd = 2'd0; m_n = 1; m_ops = 0;
    end else if (m_ph != M_IDLE && abort_in) begin
      m_ph = M_IDLE;
    end else begin
      case (m_ph)
        M_IDLE: if (start_in) begin
          m_dir = dir_in; m_admd = admd_in; m_n = int'(nops_in) + 1; m_ops = 0;
          m_ph = M_LOAD; m_t0 = cyc;
        end
        M_LOAD, M_STEP: m_ph = M_RUN;
        M_RUN: if (op_ack_in) begin
          m_ops++;
          if (m_ops % m_n == 0) m_ph = (m_ops == n_addr(m_admd) * m_n) ? M_DONE : M_STEP;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  function automatic logic [7:0] lfsr(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Scenario bookkeeping, address counter and ack generation (all on negedge)
  logic [7:0] q[$];
  logic [7:0] cur_addr = 8'd0;
  int n_req = 0, n_r = 0, n_s = 0, n_done = 0, done_rel = 0, wait_c = 0, ack_mode = 0;
  bit prev_adv = 1'b0;
  logic [10:0] exp_v, act_v;

  always @(negedge clk) begin
    exp_v = {m_ph == M_LOAD && !m_dir, m_ph == M_LOAD && m_dir,
             m_ph == M_IDLE || m_ph == M_RUN || m_ph == M_DONE,
             m_dir ? ~`ADDR_UP : `ADDR_UP, m_admd, m_ph == M_RUN,
             2'(m_ops % m_n), m_ph != M_IDLE, m_ph == M_DONE};
    act_v = {s_out, r_out, hold_out, updwn_out, admd_out, op_req_out, op_idx_out, busy_out, done_out};
    check("cycle_outputs", 32'(act_v), 32'(exp_v));

    if (op_req_out && prev_adv) q.push_back(cur_addr);
    prev_adv = busy_out && !hold_out;
    if (op_req_out) n_req++;
    if (r_out) n_r++;
    if (s_out) n_s++;
    if (done_out) begin n_done++; done_rel = cyc - m_t0 + 1; end

    if (s_out || r_out) cur_addr = (admd_out == PRUD) ? SEED : (s_out ? 8'd0 : 8'd255);
    else if (busy_out && !hold_out)
      cur_addr = (admd_out == PRUD) ? lfsr(cur_addr)
               : ((updwn_out == `ADDR_UP) ? cur_addr + 8'd1 : cur_addr - 8'd1);

    case (ack_mode)
      0: op_ack_in = 1'b1;
      1: if (op_req_out && wait_c == 3) begin op_ack_in = 1'b1; wait_c = 0; end
         else begin op_ack_in = 1'b0; if (op_req_out) wait_c++; end
      default: op_ack_in = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic clr_stats();
    q.delete(); n_req = 0; n_r = 0; n_s = 0; n_done = 0; done_rel = 0; wait_c = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_elem(input logic d, input logic [1:0] a, input logic [1:0] n);
    start_in = 1'b1; dir_in = d; admd_in = a; nops_in = n;
    tick();
    start_in = 1'b0; dir_in = $urandom_range(0, 1); nops_in = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int b = 0;
    while (busy_out !== 1'b0 && b < budget) begin tick(); b++; end
    if (b >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_addrs(input string name, input int cnt, input int budget);
    int b = 0;
    while (q.size() < cnt && b < budget) begin tick(); b++; end
    if (b >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: saw %0d addresses, wanted %0d", name, q.size(), cnt);
    end
  endtask

  function automatic int seq_errs(input bit down);
    int e = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] != (down ? 8'(255 - i) : 8'(i))) e++;
    return e;
  endfunction

  initial begin
    bit seen[256];
    int dup;
    ack_mode = 0;
    repeat (3) tick();
    @(negedge clk); #1;
    check("reset_outputs", 32'({s_out, r_out, hold_out, updwn_out, admd_out, op_req_out,
                                op_idx_out, busy_out, done_out}), 32'(RESET_VEC));
    tick(); rst = 1'b0; tick();

    // 1: LIUD ascending, one op per address, ack tied high
    clr_stats(); ack_mode = 0;
    start_elem(1'b0, LIUD, 2'd0);
    wait_idle("s1_timeout", 1000);
    check("s1_addr_count", q.size(), 256);
    check("s1_addr_seq_errs", seq_errs(1'b0), 0);
    check("s1_done_count", n_done, 1);
    check("s1_done_cycle", done_rel, 513);
    check("s1_req_cycles", n_req, 256);

    // 2: LIUD descending, four ops per address
    tick(); clr_stats();
    start_elem(1'b1, LIUD, 2'd3);
    wait_idle("s2_timeout", 2000);
    check("s2_r_pulses", n_r, 1);
    check("s2_s_pulses", n_s, 0);
    check("s2_addr_count", q.size(), 256);
    check("s2_addr_seq_errs", seq_errs(1'b1), 0);
    check("s2_req_cycles", n_req, 1024);

    // 3: pseudo-random address order
    tick(); clr_stats();
    start_elem(1'b0, PRUD, 2'd0);
    wait_idle("s3_timeout", 1000);
    check("s3_addr_count", q.size(), 255);
    check("s3_first_addr", q.size() > 0 ? 32'(q[0]) : 32'hFFFF, 32'(SEED));
    foreach (seen[i]) seen[i] = 1'b0;
    dup = 0;
    foreach (q[i]) begin if (q[i] == 8'd0 || seen[q[i]]) dup++; seen[q[i]] = 1'b1; end
    check("s3_zero_or_dup", dup, 0);
    check("s3_done_count", n_done, 1);

    // 4: ack three cycles late, stray start mid-element
    tick(); clr_stats(); ack_mode = 1;
    start_elem(1'b0, LIUD, 2'd1);
    repeat (50) tick();
    start_in = 1'b1; dir_in = 1'b1; admd_in = PRUD; tick(); start_in = 1'b0;
    wait_idle("s4_timeout", 5000);
    check("s4_req_cycles", n_req, 2048);
    check("s4_addr_seq_errs", seq_errs(1'b0), 0);
    check("s4_done_count", n_done, 1);

    // 5: abort at address 10, then reset at address 20 of a fresh element
    tick(); clr_stats();
    start_elem(1'b0, LIUD, 2'd0);
    wait_addrs("s5_reach10", 11, 200);
    check("s5_at_addr10", q.size() > 10 ? 32'(q[10]) : 32'hFFFF, 32'd10);
    abort_in = 1'b1; tick(); abort_in = 1'b0;
    @(negedge clk); #1;
    check("s5_abort_busy", 32'(busy_out), 32'd0);
    check("s5_abort_req", 32'(op_req_out), 32'd0);
    repeat (10) tick();
    check("s5_abort_no_done", n_done, 0);
    clr_stats();
    start_elem(1'b1, PRUD, 2'd2);
    wait_addrs("s5_reach20", 21, 400);
    rst = 1'b1; tick();
    @(negedge clk); #1;
    check("s5_rst_outputs", 32'({s_out, r_out, hold_out, updwn_out, admd_out, op_req_out,
                                 op_idx_out, busy_out, done_out}), 32'(RESET_VEC));
    tick(); rst = 1'b0; tick();

    // random elements: random ack, stray starts, rare aborts and resets
    ack_mode = 2;
    for (int e = 0; e < 6; e++) begin
      int b = 0;
      start_elem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      while (busy_out !== 1'b0 && b < 8000) begin
        start_in = ($urandom_range(0, 15) == 0);
        dir_in = $urandom_range(0, 1);
        admd_in = 2'($urandom_range(0, 1));
        abort_in = ($urandom_range(0, 1499) == 0);
        rst = ($urandom_range(0, 2999) == 0);
        tick(); b++;
      end
      start_in = 1'b0; abort_in = 1'b0; rst = 1'b0;
      if (b >= 8000) begin
        n_chk++; n_fail++;
        $display("FAIL rand_timeout: element %0d still busy", e);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
